uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync2.sv | 24 ++
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmitter and receiver: line timing,
// frame shape and the receiver state encoding.
package uart_pkg;

  localparam int CLKFREQ      = 12000000;
  localparam int BAUD_DEFAULT = 9600;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous input pin; both flops reset to
// RESET_VAL so the synchronized value is defined from the first cycle.
module sync2 #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples each bit at mid-cell and
// presents the recovered byte with a one-cycle valid (or frame_err) strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLKFREQ,
  parameter int BAUD     = BAUD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state,     state_d;
  logic [CNT_W-1:0]     cnt,       cnt_d;
  logic [2:0]           bit_idx,   bit_idx_d;
  logic [DATA_BITS-1:0] shreg,     shreg_d;
  logic [7:0]           data_d;
  logic                 valid_d,   frame_err_d;

  sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync_rx (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt + CNT_W'(1);
    bit_idx_d   = bit_idx;
    shreg_d     = shreg;
    data_d      = data;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end

      START: begin
        if (cnt == CNT_MID) begin
          cnt_d = '0;
          // A start bit that is high again at mid-cell was only a glitch.
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg[DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) state_d = STOP;
          else                     bit_idx_d = bit_idx + 3'd1;
        end
      end

      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shreg;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end

      BREAK: begin
        // Stay here while the line is held low so a break is not re-framed.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values
  // and the update order inside the block does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_idx_d;
      shreg     <= shreg_d;
      data      <= data_d;
      valid     <= valid_d;
      frame_err <= frame_err_d;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit; expected bytes are
// queued when a frame is driven and compared when valid strobes.
module tb_uart_rx;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLK_FREQ(16),
    .BAUD    (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  logic [7:0] exp_q[$];
  int   n_valid        = 0;
  int   n_ferr         = 0;
  int   last_valid_cyc = 0;
  logic prev_valid     = 1'b0;
  logic prev_busy      = 1'b0;

  // Scoreboard monitor: every valid strobe pops one expected byte.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (rst_n === 1'b1) begin
      if (valid === 1'b1) begin
        n_valid++;
        last_valid_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_valid: data=%h, required no strobe", data);
        end else begin
          exp_b = exp_q.pop_front();
          if (data !== exp_b) $display("FAIL rx_data: got %h, required %h", data, exp_b);
          else passed++;
        end
        total++;
        if (busy !== 1'b0) $display("FAIL busy_at_valid: got %b, required 0", busy);
        else passed++;
        total++;
        if (prev_busy !== 1'b1) $display("FAIL busy_before_valid: got %b, required 1", prev_busy);
        else passed++;
        if (prev_valid === 1'b1) begin
          total++;
          $display("FAIL valid_width: valid high 2 cycles, required 1");
        end
        if (frame_err === 1'b1) begin
          total++;
          $display("FAIL valid_and_ferr: both high, required exclusive");
        end
      end
      if (frame_err === 1'b1) n_ferr++;
    end
    prev_valid = valid;
    prev_busy  = busy;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (N) @(negedge clk);
    end
    rx = stop_bit;
    repeat (N) @(negedge clk);
  endtask

  task automatic test_reset;
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (data !== 8'h00) $display("FAIL reset_data: got %h, required 00", data); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", valid); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b, required 0", frame_err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else passed++;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_single;
    int c0, v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    exp_q.push_back(8'hA5);
    c0 = cyc;
    drive_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    total++; if (n_valid !== v0 + 1) $display("FAIL single_count: got %0d, required %0d", n_valid - v0, 1); else passed++;
    total++; if (last_valid_cyc - c0 !== 155) $display("FAIL single_latency: got %0d, required 155", last_valid_cyc - c0); else passed++;
    total++; if (n_ferr !== f0) $display("FAIL single_ferr: got %0d, required 0", n_ferr - f0); else passed++;
    total++; if (data !== 8'hA5) $display("FAIL single_hold: got %h, required a5", data); else passed++;
  endtask

  task automatic test_back_to_back;
    int v0, f0;
    logic [7:0] bytes [3];
    bytes = '{8'h00, 8'hFF, 8'h41};
    v0 = n_valid;
    f0 = n_ferr;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(bytes[i]);
      drive_frame(bytes[i], 1'b1);
    end
    repeat (20) @(negedge clk);
    total++; if (n_valid !== v0 + 3) $display("FAIL b2b_count: got %0d, required 3", n_valid - v0); else passed++;
    total++; if (n_ferr !== f0) $display("FAIL b2b_ferr: got %0d, required 0", n_ferr - f0); else passed++;
    total++; if (exp_q.size() !== 0) $display("FAIL b2b_queue: %0d left, required 0", exp_q.size()); else passed++;
  endtask

  task automatic test_glitch;
    int v0, f0, busy_cnt;
    v0 = n_valid;
    f0 = n_ferr;
    busy_cnt = 0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
    end
    total++; if (busy_cnt < 1 || busy_cnt > 10) $display("FAIL glitch_busy: got %0d cycles, required 1..10", busy_cnt); else passed++;
    total++; if (n_valid !== v0) $display("FAIL glitch_valid: got %0d, required 0", n_valid - v0); else passed++;
    total++; if (n_ferr !== f0) $display("FAIL glitch_ferr: got %0d, required 0", n_ferr - f0); else passed++;
  endtask

  task automatic test_frame_err;
    int v0, f0, wait_cnt;
    v0 = n_valid;
    f0 = n_ferr;
    drive_frame(8'h3C, 1'b0);
    repeat (64) @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL break_busy: got %b, required 1", busy); else passed++;
    rx = 1'b1;
    wait_cnt = 0;
    while (busy === 1'b1 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    total++; if (wait_cnt !== 3) $display("FAIL break_release: got %0d cycles, required 3", wait_cnt); else passed++;
    total++; if (n_ferr !== f0 + 1) $display("FAIL ferr_count: got %0d, required 1", n_ferr - f0); else passed++;
    total++; if (n_valid !== v0) $display("FAIL ferr_valid: got %0d, required 0", n_valid - v0); else passed++;
    total++; if (data !== 8'h41) $display("FAIL ferr_data_hold: got %h, required 41", data); else passed++;
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h3C);
    drive_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (n_valid !== v0 + 1) $display("FAIL ferr_recover: got %0d, required 1", n_valid - v0); else passed++;
  endtask

  task automatic test_reset_mid_frame;
    int v0, f0;
    logic [7:0] b;
    b  = 8'hC3;
    v0 = n_valid;
    f0 = n_ferr;
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (N) @(negedge clk);
    end
    rx = b[4];
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (data !== 8'h00) $display("FAIL mid_reset_data: got %h, required 00", data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b, required 0", busy); else passed++;
    total++; if (valid !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL mid_reset_strobes: got %b%b, required 00", valid, frame_err); else passed++;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (n_valid !== v0 || n_ferr !== f0)
      $display("FAIL mid_reset_abort: got %0d/%0d strobes, required 0/0", n_valid - v0, n_ferr - f0); else passed++;
    exp_q.push_back(8'h5A);
    drive_frame(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (n_valid !== v0 + 1) $display("FAIL post_reset_count: got %0d, required 1", n_valid - v0); else passed++;
    total++; if (data !== 8'h5A) $display("FAIL post_reset_data: got %h, required 5a", data); else passed++;
  endtask

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    total++;
    if (exp_q.size() !== 0) $display("FAIL final_queue: %0d bytes not received, required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
